// File: rtl/y_mux4x1_pkg.sv
// y_mux4x1_pkg
// Shared definitions for the 4:1 datapath mux.
//   DEFAULT_WIDTH : default data bus width (32 bits)
//   mux_sel_t     : named 2-bit select codes. The index is bit-reversed:
//                   c[1] picks within a pair, c[0] picks between pairs.
`timescale 1ns/1ps
package y_mux4x1_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    SEL_A0 = 2'b00,
    SEL_A1 = 2'b10,
    SEL_A2 = 2'b01,
    SEL_A3 = 2'b11
  } mux_sel_t;

endpackage

// File: rtl/y_mux4x1_if.sv
// y_mux4x1_if
// Bundles the mux data/select bus for whoever drives or consumes it.
//   a0..a3 : data inputs
//   c      : select
//   z      : combinational result
//   z_q    : registered result
// Modports:
//   master : the side that drives data and select and reads results
//   slave  : the mux side
// There is no handshake: the mux has no valid/ready; z follows the inputs
// combinationally and z_q captures z on every rising clock edge.
`timescale 1ns/1ps
interface y_mux4x1_if
  import y_mux4x1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] a2;
  logic [WIDTH-1:0] a3;
  logic [1:0]       c;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] z_q;

  modport master (
    output a0, a1, a2, a3, c,
    input  z, z_q
  );

  modport slave (
    input  a0, a1, a2, a3, c,
    output z, z_q
  );

endinterface

// File: rtl/y_mux4x1_mux2x1.sv
// y_mux2x1
// WIDTH-bit 2:1 mux built from gate primitives, one bit-slice per bit.
//   a   : input, selected when s = 0
//   b   : input, selected when s = 1
//   s   : select
//   out : s ? b : a
`timescale 1ns/1ps
module y_mux2x1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] out
);

  wire s_n;

  // The inverted select is shared by every slice.
  not u_not (s_n, s);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    wire a_term;
    wire b_term;
    and u_and_a (a_term, a[i], s_n);
    and u_and_b (b_term, b[i], s);
    or  u_or    (out[i], a_term, b_term);
  end

endmodule

// File: rtl/y_mux4x1.sv
// y_mux4x1
// Four-input WIDTH-bit mux for the CPU datapath, with a registered copy.
//   z     : output, combinational mux result
//   a0-a3 : inputs, data
//   c     : input, select (a0=00, a1=10, a2=01, a3=11)
//   clk   : input, rising-edge clock
//   rst_n : input, asynchronous active-low reset (clears z_q only)
//   z_q   : output, z registered on every rising clock edge
// The first six ports keep their historical order so existing positional
// instantiations continue to work.
`timescale 1ns/1ps
module y_mux4x1
  import y_mux4x1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  output logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [1:0]       c,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] z_q
);

  logic [WIDTH-1:0] z_lo;
  logic [WIDTH-1:0] z_hi;

  // c[1] chooses within each pair.
  y_mux2x1 #(.WIDTH(WIDTH)) u_lo (
    .a   (a0),
    .b   (a1),
    .s   (c[1]),
    .out (z_lo)
  );

  y_mux2x1 #(.WIDTH(WIDTH)) u_hi (
    .a   (a2),
    .b   (a3),
    .s   (c[1]),
    .out (z_hi)
  );

  // c[0] chooses between the pairs.
  y_mux2x1 #(.WIDTH(WIDTH)) u_out (
    .a   (z_lo),
    .b   (z_hi),
    .s   (c[0]),
    .out (z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= '0;
    end else begin
      z_q <= z;
    end
  end

endmodule

// File: tb/tb_y_mux4x1.sv
`timescale 1ns/1ps
module tb_y_mux4x1;
  import y_mux4x1_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] a0;
    logic [W-1:0] a1;
    logic [W-1:0] a2;
    logic [W-1:0] a3;
    logic [1:0]   c;
    logic [W-1:0] exp_z;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  y_mux4x1_if #(.WIDTH(W)) bus ();

  y_mux4x1 #(.WIDTH(W)) dut (
    .z     (bus.z),
    .a0    (bus.a0),
    .a1    (bus.a1),
    .a2    (bus.a2),
    .a3    (bus.a3),
    .c     (bus.c),
    .clk   (clk),
    .rst_n (rst_n),
    .z_q   (bus.z_q)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference: select written out from the encoding table.
  function automatic logic [W-1:0] model_z(input logic [W-1:0] a0, a1, a2, a3,
                                           input logic [1:0] c);
    case (c)
      2'b00:   return a0;
      2'b10:   return a1;
      2'b01:   return a2;
      default: return a3;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
      $display("  detail: a0=%h a1=%h a2=%h a3=%h c=%b z=%h z_q=%h",
               bus.a0, bus.a1, bus.a2, bus.a3, bus.c, bus.z, bus.z_q);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [W-1:0] a0, a1, a2, a3, input logic [1:0] c);
    bus.a0 = a0;
    bus.a1 = a1;
    bus.a2 = a2;
    bus.a3 = a3;
    bus.c  = c;
  endtask

  // Pop the expected registered value and compare it 1 ns after the edge.
  task automatic check_zq(input string name);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk_cnt++;
      $display("FAIL %s: got %h expected <queue empty>", name, bus.z_q);
    end else begin
      check(name, bus.z_q, exp_q.pop_front());
    end
  endtask

  // Apply one vector away from the clock edge, check z after 200 ps,
  // queue the expected z_q and check it after the next rising edge.
  task automatic apply_vec(input string name, input vec_t v);
    @(negedge clk);
    drive(v.a0, v.a1, v.a2, v.a3, v.c);
    #0.2;
    check({name, " z"}, bus.z, v.exp_z);
    exp_q.push_back(v.exp_z);
    check_zq({name, " z_q"});
  endtask

  // ---------------- test ----------------
  vec_t vecs[8];

  initial begin
    // Directed table: walk of the four selects, then per-bit patterns.
    vecs[0] = '{32'h0000_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 2'b00, 32'h0000_1111};
    vecs[1] = '{32'h0000_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 2'b10, 32'h2222_2222};
    vecs[2] = '{32'h0000_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 2'b01, 32'h3333_3333};
    vecs[3] = '{32'h0000_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 2'b11, 32'h4444_4444};
    vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555, 2'b00, 32'h0000_0000};
    vecs[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555, 2'b10, 32'hFFFF_FFFF};
    vecs[6] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555, 2'b01, 32'hAAAA_AAAA};
    vecs[7] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555, 2'b11, 32'h5555_5555};

    // Reset held with the clock running: z_q stays 0, z still tracks.
    rst_n = 1'b0;
    drive(32'h1, 32'h2, 32'h3, 32'hDEAD_BEEF, SEL_A3);
    #0.2;
    check("reset z_q async", bus.z_q, 32'h0);
    check("reset z tracks", bus.z, 32'hDEAD_BEEF);
    repeat (3) @(posedge clk);
    #1;
    check("reset z_q held", bus.z_q, 32'h0);

    // Release between edges; first rising edge captures DEADBEEF.
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    check_zq("release first edge");

    // Mid-cycle reset assertion clears z_q at once, z unaffected.
    #2;
    rst_n = 1'b0;
    #0.2;
    check("midreset z_q", bus.z_q, 32'h0);
    check("midreset z", bus.z, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    check("midreset z_q edge", bus.z_q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      apply_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Random vectors.
    for (int i = 0; i < 15; i++) begin
      vec_t v;
      v.a0 = $urandom;
      v.a1 = $urandom;
      v.a2 = $urandom;
      v.a3 = $urandom;
      v.c  = 2'($urandom_range(0, 3));
      v.exp_z = model_z(v.a0, v.a1, v.a2, v.a3, v.c);
      apply_vec($sformatf("rand%0d c=%b", i, v.c), v);
    end

    // Hold data, toggle select 01 <-> 10 within one cycle.
    begin
      logic [W-1:0] h0, h1, h2, h3;
      logic [1:0]   cs;
      h0 = $urandom;
      h1 = $urandom;
      h2 = $urandom;
      h3 = $urandom;
      @(negedge clk);
      cs = 2'b01;
      for (int k = 0; k < 6; k++) begin
        drive(h0, h1, h2, h3, cs);
        #0.2;
        check($sformatf("toggle%0d", k), bus.z, (cs == 2'b01) ? h2 : h1);
        cs = (cs == 2'b01) ? 2'b10 : 2'b01;
      end
      exp_q.push_back(model_z(h0, h1, h2, h3, bus.c));
      check_zq("toggle z_q");
    end

    // ---------------- report ----------------
    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL scoreboard drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
